// File: rtl/coin_start_sequencer.sv
// Turns a raw Start 1P/2P press into a frame-timed coin pulse train followed by a
// start pulse, feeding the core's coin and select inputs.
module coin_start_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       vblank,
    input  logic       req_start1,
    input  logic       req_start2,
    output logic       o_coin,
    output logic [1:0] o_start,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       coins_left;
    logic       sel;
    logic [1:0] s1, s2, prev;
    logic [1:0] fill;
    logic       vblank_d;
    logic       tick;
    logic       expire;
    logic [1:0] edge_req;

    if (COIN_FRAMES < 1 || COIN_FRAMES > 255) begin : g_bad_coin
        $error("COIN_FRAMES must be in 1..255");
    end
    if (GAP_FRAMES < 1 || GAP_FRAMES > 255) begin : g_bad_gap
        $error("GAP_FRAMES must be in 1..255");
    end
    if (START_FRAMES < 1 || START_FRAMES > 255) begin : g_bad_start
        $error("START_FRAMES must be in 1..255");
    end

    assign tick     = vblank & ~vblank_d;
    assign expire   = tick && (cnt == 8'd1);
    assign edge_req = s2 & ~prev;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            coins_left <= 1'b0;
            sel        <= 1'b0;
            s1         <= 2'b00;
            s2         <= 2'b00;
            prev       <= 2'b11;
            fill       <= 2'd0;
            vblank_d   <= 1'b0;
        end else begin
            s1       <= {req_start2, req_start1};
            s2       <= s1;
            vblank_d <= vblank;
            // prev holds its reset value of 1 until the synchroniser has refilled,
            // otherwise a button held through reset would look like a fresh press.
            if (fill != 2'd2) fill <= fill + 2'd1;
            else              prev <= s2;

            if (tick && cnt != 8'd0) cnt <= cnt - 8'd1;

            case (state)
                IDLE: begin
                    if (edge_req[0]) begin
                        sel        <= 1'b0;
                        coins_left <= 1'b0;
                        state      <= COIN;
                        cnt        <= 8'(COIN_FRAMES);
                    end else if (edge_req[1]) begin
                        sel        <= 1'b1;
                        coins_left <= 1'b1;
                        state      <= COIN;
                        cnt        <= 8'(COIN_FRAMES);
                    end
                end
                COIN: if (expire) begin
                    state <= GAP;
                    cnt   <= 8'(GAP_FRAMES);
                end
                GAP: if (expire) begin
                    if (coins_left) begin
                        coins_left <= 1'b0;
                        state      <= COIN;
                        cnt        <= 8'(COIN_FRAMES);
                    end else begin
                        state <= START;
                        cnt   <= 8'(START_FRAMES);
                    end
                end
                START:   if (expire) state <= RELEASE;
                RELEASE: if (s2 == 2'b00) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_coin  = (state == COIN);
    assign o_start = (state == START) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Bench for coin_start_sequencer: output segments are measured in frame ticks and
// checked against an expected-segment queue filled when each press is driven.
module tb_coin_start_sequencer;

    localparam int CF = 4;
    localparam int GF = 8;
    localparam int SF = 4;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       vblank;
    logic       req_start1;
    logic       req_start2;
    logic       o_coin;
    logic [1:0] o_start;
    logic       busy;

    typedef struct {
        logic [2:0] val;
        int         ticks;
    } seg_t;

    typedef struct {
        logic       r1;
        logic       r2;
        int         pre;
        logic [2:0] start_val;
        int         coins;
    } vec_t;

    seg_t       exp_q[$];
    vec_t       tbl[5];
    int         n_vec = 0;
    int         n_err = 0;
    int         phase = 0;
    logic [2:0] seg_val;
    int         seg_ticks;
    bit         seg_on = 1'b0;

    coin_start_sequencer #(
        .COIN_FRAMES (CF),
        .GAP_FRAMES  (GF),
        .START_FRAMES(SF)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .req_start1(req_start1),
        .req_start2(req_start2),
        .o_coin    (o_coin),
        .o_start   (o_start),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Frame generator (vblank rises every 20 cycles) and output-segment monitor.
    // Each negedge sample is one DUT cycle: its outputs plus the tick it will see.
    initial begin
        logic       vb_old;
        logic       tick_now;
        logic [2:0] cur;
        seg_t       e;
        vblank = 1'b0;
        forever begin
            @(negedge clk_sys);
            phase    = (phase == 19) ? 0 : phase + 1;
            vb_old   = vblank;
            vblank   = (phase < 10);
            tick_now = vblank & ~vb_old;
            cur      = {o_coin, o_start};
            if (!busy) begin
                seg_on = 1'b0;
            end else if (seg_on && cur == seg_val) begin
                seg_ticks += int'(tick_now);
            end else begin
                if (seg_on) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL seg_extra: got val=%b ticks=%0d, expected no segment",
                                 seg_val, seg_ticks);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.val != seg_val || e.ticks != seg_ticks) begin
                            n_err++;
                            $display("FAIL seg: got val=%b ticks=%0d, expected val=%b ticks=%0d",
                                     seg_val, seg_ticks, e.val, e.ticks);
                        end
                    end
                end
                seg_on    = 1'b1;
                seg_val   = cur;
                seg_ticks = int'(tick_now);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(logic [2:0] val, int ticks);
        seg_t e;
        e.val   = val;
        e.ticks = ticks;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(logic [2:0] start_val, int coins);
        for (int j = 0; j < coins; j++) begin
            push_seg(3'b100, CF);
            push_seg(3'b000, GF);
        end
        push_seg(start_val, SF);
    endtask

    task automatic wait_idle(string name, int limit);
        int k = 0;
        while (busy && k < limit) begin
            step();
            k++;
        end
        chk(name, int'(busy), 0);
    endtask

    initial begin
        int k;
        bit any_busy;

        reset_n    = 1'b0;
        req_start1 = 1'b0;
        req_start2 = 1'b0;
        step(3);
        chk("rst_coin", int'(o_coin), 0);
        chk("rst_start", int'(o_start), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        step(5);

        // r1, r2, idle cycles before press, expected start bits, expected coins
        tbl[0] = '{1'b1, 1'b0, 0,  3'b001, 1};
        tbl[1] = '{1'b0, 1'b1, 3,  3'b010, 2};
        tbl[2] = '{1'b1, 1'b1, 7,  3'b001, 1};
        tbl[3] = '{1'b0, 1'b1, 11, 3'b010, 2};
        tbl[4] = '{1'b1, 1'b0, 16, 3'b001, 1};
        foreach (tbl[i]) begin
            step(tbl[i].pre);
            push_seq(tbl[i].start_val, tbl[i].coins);
            req_start1 = tbl[i].r1;
            req_start2 = tbl[i].r2;
            step(5);
            req_start1 = 1'b0;
            req_start2 = 1'b0;
            wait_idle($sformatf("idle_v%0d", i), 1000);
            chk($sformatf("drain_v%0d", i), exp_q.size(), 0);
        end

        // Press timed so the tick lands on the cycle that enters COIN; also checks
        // the two-cycle synchroniser latency.
        k = 0;
        while (phase != 18 && k < 40) begin
            step();
            k++;
        end
        push_seq(3'b001, 1);
        req_start1 = 1'b1;
        step(); chk("lat_c1", int'(o_coin), 0);
        step(); chk("lat_c2", int'(o_coin), 0);
        step(); chk("lat_c3", int'(o_coin), 1);
        step(2);
        req_start1 = 1'b0;
        wait_idle("idle_align", 1000);
        chk("drain_align", exp_q.size(), 0);

        // Start 2P pulsed during COIN is dropped.
        push_seq(3'b001, 1);
        req_start1 = 1'b1;
        step(5);
        req_start1 = 1'b0;
        chk("ign_in_coin", int'(o_coin), 1);
        req_start2 = 1'b1;
        step(5);
        req_start2 = 1'b0;
        wait_idle("idle_ign", 1000);
        chk("drain_ign", exp_q.size(), 0);

        // Button held for 60 frames: one sequence, then parked in RELEASE.
        push_seq(3'b001, 1);
        req_start1 = 1'b1;
        step(60 * 20);
        chk("held_busy", int'(busy), 1);
        chk("held_drain", exp_q.size(), 0);
        req_start1 = 1'b0;
        step(2); chk("rel_c2", int'(busy), 1);
        step(1); chk("rel_c3", int'(busy), 0);
        step(50); chk("rel_stay_idle", int'(busy), 0);

        // Reset in the first GAP of a 2P sequence.
        push_seq(3'b010, 2);
        req_start2 = 1'b1;
        step(5);
        req_start2 = 1'b0;
        k = 0;
        while (o_coin && k < 200) begin
            step();
            k++;
        end
        chk("gap_reached", int'(o_coin), 0);
        step(20);
        chk("gap_busy", int'(busy), 1);
        reset_n = 1'b0;
        step();
        chk("rstgap_coin", int'(o_coin), 0);
        chk("rstgap_start", int'(o_start), 0);
        chk("rstgap_busy", int'(busy), 0);
        chk("rstgap_left", exp_q.size(), 4);
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(5);

        // Button held across reset release must not start a sequence.
        req_start1 = 1'b1;
        reset_n    = 1'b0;
        step(3);
        reset_n  = 1'b1;
        any_busy = 1'b0;
        repeat (200) begin
            step();
            if (busy) any_busy = 1'b1;
        end
        chk("held_rst_nobusy", int'(any_busy), 0);
        req_start1 = 1'b0;
        step(10);
        push_seq(3'b001, 1);
        req_start1 = 1'b1;
        step(5);
        req_start1 = 1'b0;
        wait_idle("idle_repress", 1000);
        chk("drain_repress", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coin_start_sequencer.md
Name: coin_start_sequencer

Overview:
- Input-conditioning stage that sits directly upstream of the ladybug core's coin and select inputs.
- Converts a player's raw Start 1P / Start 2P press (keyboard F1/F2 or joystick) into a frame-timed sequence: coin pulse(s), then a start pulse.
- Replaces the level-based coin = start1|start2 drive.
- Outputs are active-high; the top level inverts them into but_coin_s / but_select_s.

Parameters:
COIN_FRAMES, 4, frames o_coin is held high per coin (1..255)
GAP_FRAMES, 8, frames of low gap after each coin pulse (1..255)
START_FRAMES, 4, frames o_start bit is held high (1..255)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
vblank  in  1  core vertical blank, clk_sys domain; rising edge = frame tick
req_start1  in  1  raw Start 1P request, active-high level, may be asynchronous
req_start2  in  1  raw Start 2P request, active-high level, may be asynchronous
o_coin  out  1  coin pulse to core, active-high
o_start  out  2  [0]=select 1P, [1]=select 2P, active-high, one-hot or zero
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset_n low at a clock edge):
  - State = IDLE; o_coin=0, o_start=0, busy=0.
  - Frame counter=0, coins_left=0, sel=0, sync FFs=0.
  - Edge-detect "prev" registers = 1, so a button held through reset makes no request until released and pressed again.
  - Reset mid-sequence aborts immediately; outputs are 0 on the first clock after reset is sampled.
- Synchronisers:
  - Each req passes through a 2-FF synchroniser (s1, s2).
  - Request edge = s2 & ~prev, where prev <= s2.
- Frame tick: tick = vblank & ~vblank_d, one clk_sys cycle wide. vblank is not synchronised.
- Counter: 8-bit down-counter cnt.
  - Loaded with N on entry to a timed state; decremented on each tick.
  - The state exits on the cycle where tick && cnt==1, i.e. on the Nth tick after entry.
  - A tick on the entry cycle is not counted.
- States:
  - IDLE: no outputs.
    - On req_start1 edge: sel=0, coins_left=0, go to COIN.
    - Else on req_start2 edge: sel=1, coins_left=1, go to COIN.
    - Simultaneous edges: start1 wins.
    - Load cnt=COIN_FRAMES.
  - COIN: o_coin=1. On expiry go to GAP, cnt=GAP_FRAMES.
  - GAP: o_coin=0. On expiry:
    - if coins_left!=0: decrement coins_left, go to COIN, cnt=COIN_FRAMES;
    - else go to START, cnt=START_FRAMES.
  - START: o_start[sel]=1. On expiry go to RELEASE.
  - RELEASE: waits until s2 of both requests is 0, then goes to IDLE. prev registers stay updated, so a still-held button does not retrigger.
- Request edges outside IDLE are ignored and not queued.
- Outputs are decoded from the state register only: no combinational path from inputs, no extra latency.
- Latency: req rises before clock edge k → s1 at k, s2 at k+1, COIN (o_coin=1) after edge k+2.
- Parameter value 0 is illegal; an elaboration-time assertion is required.

Test Plan:
- Bench setup: COIN_FRAMES=4, GAP_FRAMES=8, START_FRAMES=4; vblank rising every 20 clk_sys cycles.
- 1P sequence: pulse req_start1 high for 5 cycles → o_coin high exactly 2 cycles after the sampled rise, for exactly 4 ticks; low 8 ticks; o_start=2'b01 for 4 ticks; then busy=0.
- 2P sequence: req_start2 press → two o_coin pulses (4 ticks each, 8-tick gaps), then o_start=2'b10 for 4 ticks. o_start is never 2'b11.
- Simultaneous and ignored requests:
  - req_start1 and req_start2 rise on the same cycle → 1P sequence (single coin, o_start=01).
  - req_start2 pulsed during COIN → ignored; no second coin.
- Held button: hold req_start1 for 60 frames → exactly one sequence; state stays RELEASE (busy=1) until release, then IDLE within 3 cycles.
- Reset cases:
  - Assert reset_n=0 during the GAP of a 2P sequence → o_coin, o_start, busy all 0 next cycle.
  - Button held across reset release → no sequence until release and re-press.
- Tick alignment: vblank rise on the same cycle as entry to COIN → that tick is not counted; o_coin lasts 4 further ticks.
